// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and codes for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_AW = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // D-stage operand mux select codes
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Operand forward select for one D-stage source register; E result wins over W.
module fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int AW = pipeline_hazard_ctrl_pkg::REG_AW
) (
    input  logic [AW-1:0] rs,
    input  logic          src_used,
    input  logic [AW-1:0] rd_e,
    input  logic          regwrite_e,
    input  logic          memread_e,
    input  logic [AW-1:0] rd_w,
    input  logic          regwrite_w,
    output logic [1:0]    sel
);

    // A load in E has no data yet, so it never forwards from E.
    always_comb begin
        sel = FWD_RF;
        if (src_used && regwrite_e && (rd_e != '0) && (rd_e == rs) && !memread_e)
            sel = FWD_E;
        else if (src_used && regwrite_w && (rd_w != '0) && (rd_w == rs))
            sel = FWD_W;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the F/D/E/W pipeline with perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = pipeline_hazard_ctrl_pkg::REG_AW,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic              rs1_useD,
    input  logic              rs2_useD,
    input  logic [REG_AW-1:0] rdE,
    input  logic              regwriteE,
    input  logic              memreadE,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regwriteW,
    input  logic              branch_takenE,
    input  logic              mem_reqE,
    input  logic              mem_ack,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic [1:0]        fwdA,
    output logic [1:0]        fwdB,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int TM_W = $clog2(MEM_TIMEOUT + 1);

    state_t          state, state_next;
    logic [FC_W-1:0] fc;
    logic [TM_W-1:0] timer;
    logic            load_use;
    logic            fc_load, fc_dec, timer_start, timer_inc, flush_inc;

    fwd_unit #(.AW(REG_AW)) u_fwd_a (
        .rs(rs1D), .src_used(rs1_useD), .rd_e(rdE), .regwrite_e(regwriteE),
        .memread_e(memreadE), .rd_w(rdW), .regwrite_w(regwriteW), .sel(fwdA)
    );

    fwd_unit #(.AW(REG_AW)) u_fwd_b (
        .rs(rs2D), .src_used(rs2_useD), .rd_e(rdE), .regwrite_e(regwriteE),
        .memread_e(memreadE), .rd_w(rdW), .regwrite_w(regwriteW), .sel(fwdB)
    );

    assign load_use = memreadE && regwriteE && (rdE != '0) &&
                      ((rs1_useD && (rdE == rs1D)) || (rs2_useD && (rdE == rs2D)));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    // Next state and stage enables; memory wait beats branch beats load-use
    always_comb begin
        state_next  = state;
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        fc_load     = 1'b0;
        fc_dec      = 1'b0;
        timer_start = 1'b0;
        timer_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (state)
            RUN: begin
                if (mem_reqE && !mem_ack) begin
                    {stallF, stallD, stallE} = 3'b111;
                    timer_start = 1'b1;
                    state_next  = MEM_WAIT;
                end else if (branch_takenE) begin
                    flushD    = 1'b1;
                    flushE    = 1'b1;
                    flush_inc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        fc_load    = 1'b1;
                        state_next = FLUSH;
                    end
                end else if (load_use) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_next = RUN;
                end else begin
                    {stallF, stallD, stallE} = 3'b111;
                    timer_inc = 1'b1;
                end
            end
            FLUSH: begin
                flushD = 1'b1;
                fc_dec = 1'b1;
                if (fc <= FC_W'(1)) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Remaining flush cycles after the branch cycle itself
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       fc <= '0;
        else if (fc_load) fc <= FC_W'(FLUSH_CYCLES - 1);
        else if (fc_dec)  fc <= fc - 1'b1;
    end

    // Wait timer counts stalled cycles of the current access; saturates at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            timer <= '0;
        else if (timer_start)
            timer <= TM_W'(1);
        else if (timer_inc && (timer < TM_W'(MEM_TIMEOUT)))
            timer <= timer + 1'b1;
    end

    // Sticky timeout flag, set on the edge where the stalled-cycle count reaches the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mem_err <= 1'b0;
        else if ((timer_start && (MEM_TIMEOUT <= 1)) ||
                 (timer_inc && (timer >= TM_W'(MEM_TIMEOUT - 1))))
            mem_err <= 1'b1;
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallF && (stall_cnt != '1))    stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int AW   = 4;
    localparam int FC   = 2;
    localparam int MT   = 6;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] rs1D, rs2D, rdE, rdW;
    logic          rs1_useD, rs2_useD, regwriteE, memreadE, regwriteW;
    logic          branch_takenE, mem_reqE, mem_ack;
    logic          stallF, stallD, stallE, flushD, flushE, mem_err;
    logic [1:0]    fwdA, fwdB;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_AW(AW), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1_useD(rs1_useD), .rs2_useD(rs2_useD),
        .rdE(rdE), .regwriteE(regwriteE), .memreadE(memreadE),
        .rdW(rdW), .regwriteW(regwriteW),
        .branch_takenE(branch_takenE), .mem_reqE(mem_reqE), .mem_ack(mem_ack),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .fwdA(fwdA), .fwdB(fwdB),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending flush cycles, whether an access is outstanding and for how long
    int   m_flush_left, m_wait_len, m_scnt, m_fcnt;
    bit   m_wait, m_err;
    logic e_stf, e_std, e_ste, e_fld, e_fle;
    logic [1:0] e_fa, e_fb;

    function automatic logic [1:0] ref_fwd(logic u, logic [AW-1:0] rs);
        if (u && regwriteE && rdE != 0 && rdE == rs && !memreadE) return 2'b01;
        if (u && regwriteW && rdW != 0 && rdW == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_flush_left = 0; m_wait_len = 0; m_scnt = 0; m_fcnt = 0;
        m_wait = 0; m_err = 0;
    endtask

    task automatic model_eval();
        bit lu;
        lu = memreadE && regwriteE && rdE != 0 &&
             ((rs1_useD && rdE == rs1D) || (rs2_useD && rdE == rs2D));
        {e_stf, e_std, e_ste, e_fld, e_fle} = 5'b0;
        e_fa = ref_fwd(rs1_useD, rs1D);
        e_fb = ref_fwd(rs2_useD, rs2D);
        if (m_flush_left > 0) e_fld = 1'b1;
        else if (m_wait) begin
            if (!mem_ack) {e_stf, e_std, e_ste} = 3'b111;
        end
        else if (mem_reqE && !mem_ack) {e_stf, e_std, e_ste} = 3'b111;
        else if (branch_takenE) begin e_fld = 1'b1; e_fle = 1'b1; end
        else if (lu) begin e_stf = 1'b1; e_std = 1'b1; e_fle = 1'b1; end
    endtask

    task automatic model_clock();
        if (e_stf && m_scnt < MAXC) m_scnt++;
        if (m_flush_left > 0) m_flush_left--;
        else if (m_wait) begin
            if (mem_ack) m_wait = 0;
            else begin
                m_wait_len++;
                if (m_wait_len >= MT) m_err = 1;
            end
        end
        else if (mem_reqE && !mem_ack) begin
            m_wait = 1; m_wait_len = 1;
            if (m_wait_len >= MT) m_err = 1;
        end
        else if (branch_takenE) begin
            if (m_fcnt < MAXC) m_fcnt++;
            m_flush_left = FC - 1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model at the falling edge
    task automatic sample(string tag);
        @(negedge clk);
        model_eval();
        chk(tag, {14'b0, stallF, stallD, stallE, flushD, flushE, fwdA, fwdB, mem_err, stall_cnt, flush_cnt},
                 {14'b0, e_stf, e_std, e_ste, e_fld, e_fle, e_fa, e_fb, m_err, CW'(m_scnt), CW'(m_fcnt)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        rs1D = '0; rs2D = '0; rdE = '0; rdW = '0;
        rs1_useD = 0; rs2_useD = 0; regwriteE = 0; memreadE = 0; regwriteW = 0;
        branch_takenE = 0; mem_reqE = 0; mem_ack = 0;
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        chk("reset_outs", {stallF, stallD, stallE, flushD, flushE, fwdA, fwdB, mem_err}, 0);
        chk("reset_cnts", {stall_cnt, flush_cnt}, 0);
        @(posedge clk); #1 reset = 1'b1;

        // Forwarding: E, E beats W, then W once E has no destination
        rdE = 3; regwriteE = 1; rs1D = 3; rs1_useD = 1;
        sample("fwd_e");    chk("fwdA_e", fwdA, 2'b01);    tick();
        rdW = 3; regwriteW = 1;
        sample("fwd_ew");   chk("fwdA_e_over_w", fwdA, 2'b01); tick();
        rdE = 0;
        sample("fwd_w");    chk("fwdA_w", fwdA, 2'b10);    tick();

        // Load-use bubble then forward from W
        idle(); rdE = 5; regwriteE = 1; memreadE = 1; rs2D = 5; rs2_useD = 1;
        sample("lu");       chk("lu_ctl", {stallF, stallD, stallE, flushD, flushE}, 5'b11001); tick();
        idle(); rdW = 5; regwriteW = 1; rs2D = 5; rs2_useD = 1;
        sample("lu_after"); chk("lu_fwdB", fwdB, 2'b10);
        chk("lu_after_ctl", {stallF, stallD, stallE, flushD, flushE}, 0); tick();

        // Branch: two flush cycles
        idle(); branch_takenE = 1;
        sample("br0"); chk("br0_fl", {flushD, flushE}, 2'b11); tick();
        idle();
        sample("br1"); chk("br1_fl", {flushD, flushE}, 2'b10); tick();
        sample("br2"); chk("br2_fl", {flushD, flushE}, 2'b00); chk("br_cnt", flush_cnt, 1); tick();

        // Reset asserted while in FLUSH
        branch_takenE = 1; sample("br_rst"); tick();
        idle(); #1 reset = 1'b0; model_reset();
        #1 chk("rst_mid_flush", {flushD, flushE, stallF}, 0);
        chk("rst_mid_cnts", {stall_cnt, flush_cnt}, 0);
        @(posedge clk); #1 reset = 1'b1;
        sample("rst_release"); chk("rst_run_flushD", flushD, 0); tick();

        // Memory access acked after 4 stalled cycles
        mem_reqE = 1;
        for (int i = 0; i < 4; i++) begin
            sample("mem_wait"); chk("mem_stall", {stallF, stallD, stallE}, 3'b111); tick();
        end
        mem_ack = 1; sample("mem_ack"); chk("mem_ack_stall", {stallF, stallD, stallE}, 0); tick();
        idle(); sample("mem_done"); chk("mem_scnt", stall_cnt, 4); chk("mem_noerr", mem_err, 0); tick();

        // Timeout: 7 stalled cycles exceed MT=6, flag is sticky
        mem_reqE = 1;
        for (int i = 0; i < 7; i++) begin sample("to_wait"); tick(); end
        mem_ack = 1; sample("to_ack"); tick();
        idle();
        for (int i = 0; i < 3; i++) begin sample("to_after"); chk("mem_err_sticky", mem_err, 1); tick(); end

        // Branch and load-use together: flush wins
        branch_takenE = 1; rdE = 5; regwriteE = 1; memreadE = 1; rs1D = 5; rs1_useD = 1;
        sample("br_lu"); chk("br_lu_ctl", {stallF, stallD, flushD, flushE}, 4'b0011); tick();
        idle(); sample("br_lu_1"); tick();

        // Saturation of both counters
        mem_reqE = 1;
        for (int i = 0; i < 20; i++) begin sample("sat_stall"); tick(); end
        mem_ack = 1; sample("sat_ack"); tick();
        idle(); sample("sat_s"); chk("stall_sat", stall_cnt, MAXC); tick();
        for (int i = 0; i < 18; i++) begin
            branch_takenE = 1; sample("sat_br"); tick();
            idle(); sample("sat_fl"); tick();
        end
        sample("sat_f"); chk("flush_sat", flush_cnt, MAXC); tick();

        // Randomized traffic from a clean reset
        #1 reset = 1'b0; model_reset();
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rs1D = AW'($urandom_range(0, 3)); rs2D = AW'($urandom_range(0, 3));
            rdE  = AW'($urandom_range(0, 3)); rdW  = AW'($urandom_range(0, 3));
            rs1_useD = 1'($urandom); rs2_useD = 1'($urandom);
            regwriteE = 1'($urandom); memreadE = 1'($urandom); regwriteW = 1'($urandom);
            branch_takenE = ($urandom_range(0, 5) == 0);
            mem_reqE = ($urandom_range(0, 4) == 0);
            mem_ack = ($urandom_range(0, 3) == 0);
            sample("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
